// File: rtl/yarp_data_ram.sv
// yarp_data_ram: word-organised data RAM with req/gnt handshake, programmable wait states and byte/half/word access.
module yarp_data_ram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        data_mem_req_i,
   input  logic [31:0] data_mem_addr_i,
   input  logic [1:0]  data_mem_byte_en_i,
   input  logic        data_mem_wr_i,
   input  logic [31:0] data_mem_wr_data_i,
   output logic        data_mem_gnt_o,
   output logic        data_mem_rvalid_o,
   output logic [31:0] data_mem_rd_data_o,
   output logic        data_mem_err_o
);
   localparam int AW = $clog2(DEPTH_WORDS);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state, next;
   logic [3:0] cnt;
   logic [31:0] addr_q, wdata_q, rd_q;
   logic [1:0] be_q;
   logic wr_q, err_q;
   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] a, wd, wd_sh, word, sh, rdata;
   logic [1:0] be;
   logic [3:0] lane;
   logic [AW-1:0] idx;
   logic wr, err, commit;
   // With zero wait states the access completes on the grant edge, so decode straight from the inputs in IDLE.
   always_comb begin
      a = (state == IDLE) ? data_mem_addr_i : addr_q;
      be = (state == IDLE) ? data_mem_byte_en_i : be_q;
      wr = (state == IDLE) ? data_mem_wr_i : wr_q;
      wd = (state == IDLE) ? data_mem_wr_data_i : wdata_q;
      idx = a[AW+1:2];
      err = (be == 2'b10) || (be == 2'b01 && a[0]) || (be == 2'b11 && a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'h0);
      lane = (be == 2'b11) ? 4'hF : (be == 2'b01) ? (a[1] ? 4'hC : 4'h3) : (4'b0001 << a[1:0]);
      wd_sh = (be == 2'b00) ? {4{wd[7:0]}} : (be == 2'b01) ? {2{wd[15:0]}} : wd;
      word = mem[idx];
      sh = word >> {a[1:0], 3'b000};
      rdata = (be == 2'b00) ? {24'h0, sh[7:0]} : (be == 2'b01) ? {16'h0, sh[15:0]} : word;
      next = (state == IDLE) ? (data_mem_req_i ? ((WAIT_CYCLES > 0) ? WAIT : RESP) : IDLE)
           : (state == WAIT) ? ((cnt <= 4'd1) ? RESP : WAIT) : IDLE;
      commit = reset_n && next == RESP && state != RESP;
   end
   assign data_mem_gnt_o = reset_n && state == IDLE && data_mem_req_i;
   assign data_mem_rvalid_o = state == RESP;
   assign data_mem_rd_data_o = data_mem_rvalid_o ? rd_q : 32'h0;
   assign data_mem_err_o = data_mem_rvalid_o && err_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt <= 4'd0;
         addr_q <= 32'h0;
         be_q <= 2'b00;
         wr_q <= 1'b0;
         wdata_q <= 32'h0;
         rd_q <= 32'h0;
         err_q <= 1'b0;
      end else begin
         state <= next;
         cnt <= data_mem_gnt_o ? 4'(WAIT_CYCLES) : (state == WAIT) ? cnt - 4'd1 : cnt;
         if (data_mem_gnt_o) begin
            addr_q <= data_mem_addr_i;
            be_q <= data_mem_byte_en_i;
            wr_q <= data_mem_wr_i;
            wdata_q <= data_mem_wr_data_i;
         end
         if (commit) begin
            rd_q <= (wr || err) ? 32'h0 : rdata;
            err_q <= err;
         end
      end
   end
   // Storage is deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk) begin
      if (commit && wr && !err)
         for (int i = 0; i < 4; i++)
            if (lane[i]) mem[idx][8*i +: 8] <= wd_sh[8*i +: 8];
   end
endmodule

// File: tb/tb_yarp_data_ram.sv
// tb_yarp_data_ram: table-driven scoreboard bench for yarp_data_ram (WAIT_CYCLES=1 main instance, WAIT_CYCLES=0 throughput instance).
module tb_yarp_data_ram;
   logic clk, reset_n;
   logic req, wr, gnt, rvalid, err;
   logic [1:0] be;
   logic [31:0] addr, wdata, rd;
   logic req0, wr0, gnt0, rvalid0, err0;
   logic [1:0] be0;
   logic [31:0] addr0, wdata0, rd0;
   int n_cmp = 0, n_err = 0;
   logic [32:0] sb [$];
   typedef struct {
      logic wr;
      logic [1:0] be;
      logic [31:0] addr, wdata, rd;
      logic err;
   } vec_t;
   vec_t vt [$];

   yarp_data_ram #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut (
      .clk(clk), .reset_n(reset_n), .data_mem_req_i(req), .data_mem_addr_i(addr),
      .data_mem_byte_en_i(be), .data_mem_wr_i(wr), .data_mem_wr_data_i(wdata),
      .data_mem_gnt_o(gnt), .data_mem_rvalid_o(rvalid), .data_mem_rd_data_o(rd), .data_mem_err_o(err));

   yarp_data_ram #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .data_mem_req_i(req0), .data_mem_addr_i(addr0),
      .data_mem_byte_en_i(be0), .data_mem_wr_i(wr0), .data_mem_wr_data_i(wdata0),
      .data_mem_gnt_o(gnt0), .data_mem_rvalid_o(rvalid0), .data_mem_rd_data_o(rd0), .data_mem_err_o(err0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every response popped against the expectation pushed at grant time.
   always @(negedge clk) begin
      if (rvalid) begin
         if (sb.size() == 0) check("unexpected_rvalid", 33'd1, 33'd0);
         else check("response", {err, rd}, sb.pop_front());
      end else
         check("idle_outputs_zero", {err, rd}, 33'h0);
   end

   task automatic issue(input logic w, input logic [1:0] b, input logic [31:0] ad, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err);
      int n;
      @(negedge clk);
      wr = w; be = b; addr = ad; wdata = d; req = 1'b1;
      #1 check("gnt_same_cycle", {32'h0, gnt}, 33'd1);
      sb.push_back({exp_err, exp_rd});
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      n = 1;
      while (!rvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rvalid_latency", 33'(n), 33'd2);
   endtask

   initial begin
      vt.push_back('{1'b1, 2'b11, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
      vt.push_back('{1'b0, 2'b11, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
      vt.push_back('{1'b1, 2'b11, 32'h10, 32'h11223344, 32'h0, 1'b0});
      vt.push_back('{1'b1, 2'b00, 32'h13, 32'hFFFFFFAA, 32'h0, 1'b0});
      vt.push_back('{1'b0, 2'b00, 32'h13, 32'h0, 32'h000000AA, 1'b0});
      vt.push_back('{1'b0, 2'b11, 32'h10, 32'h0, 32'hAA223344, 1'b0});
      vt.push_back('{1'b0, 2'b01, 32'h12, 32'h0, 32'h0000AA22, 1'b0});
      vt.push_back('{1'b0, 2'b01, 32'h11, 32'h0, 32'h0, 1'b1});
      vt.push_back('{1'b0, 2'b11, 32'h10, 32'h0, 32'hAA223344, 1'b0});
      vt.push_back('{1'b1, 2'b11, 32'h0, 32'h01020304, 32'h0, 1'b0});
      vt.push_back('{1'b1, 2'b11, 32'h1000, 32'hBAD0BAD0, 32'h0, 1'b1});
      vt.push_back('{1'b0, 2'b11, 32'h0, 32'h0, 32'h01020304, 1'b0});
      vt.push_back('{1'b0, 2'b10, 32'h0, 32'h0, 32'h0, 1'b1});
      vt.push_back('{1'b0, 2'b11, 32'h2, 32'h0, 32'h0, 1'b1});
      vt.push_back('{1'b0, 2'b11, 32'h80000000, 32'h0, 32'h0, 1'b1});
      vt.push_back('{1'b1, 2'b11, 32'h14, 32'hCAFEF00D, 32'h0, 1'b0});
      vt.push_back('{1'b1, 2'b01, 32'h16, 32'h1234BEEF, 32'h0, 1'b0});
      vt.push_back('{1'b0, 2'b01, 32'h14, 32'h0, 32'h0000F00D, 1'b0});
      vt.push_back('{1'b0, 2'b00, 32'h15, 32'h0, 32'h000000F0, 1'b0});
      vt.push_back('{1'b1, 2'b01, 32'h15, 32'h55555555, 32'h0, 1'b1});
      vt.push_back('{1'b0, 2'b11, 32'h14, 32'h0, 32'hBEEFF00D, 1'b0});
      vt.push_back('{1'b1, 2'b11, 32'hFFC, 32'h5A5A5A5A, 32'h0, 1'b0});
      vt.push_back('{1'b0, 2'b11, 32'hFFC, 32'h0, 32'h5A5A5A5A, 1'b0});
      vt.push_back('{1'b1, 2'b11, 32'h20, 32'h11111111, 32'h0, 1'b0});

      reset_n = 1'b0;
      req = 1'b1; wr = 1'b0; be = 2'b11; addr = 32'h0; wdata = 32'h0;
      req0 = 1'b0; wr0 = 1'b1; be0 = 2'b11; addr0 = 32'h40; wdata0 = 32'h0BADF00D;
      repeat (2) @(negedge clk);
      check("reset_gnt", {32'h0, gnt}, 33'd0);
      check("reset_rvalid", {32'h0, rvalid}, 33'd0);
      check("reset_rd_err", {err, rd}, 33'h0);
      req = 1'b0;
      reset_n = 1'b1;

      // Zero-wait instance with req held high: grant and strobe alternate.
      @(negedge clk);
      req0 = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         #1;
         check("thru_gnt", {32'h0, gnt0}, 33'((k % 2) == 0));
         check("thru_rvalid", {32'h0, rvalid0}, 33'((k % 2) == 1));
         check("thru_rd_err", {err0, rd0}, 33'h0);
         if (k < 8) @(negedge clk);
      end
      req0 = 1'b0;
      @(negedge clk);
      wr0 = 1'b0; req0 = 1'b1;
      #1 check("w0_load_gnt", {32'h0, gnt0}, 33'd1);
      @(posedge clk);
      #1 req0 = 1'b0;
      @(negedge clk);
      check("w0_load_rvalid", {32'h0, rvalid0}, 33'd1);
      check("w0_load_data", {err0, rd0}, {1'b0, 32'h0BADF00D});

      for (int i = 0; i < vt.size(); i++)
         issue(vt[i].wr, vt[i].be, vt[i].addr, vt[i].wdata, vt[i].rd, vt[i].err);

      // Reset during WAIT aborts the store and produces no response.
      @(negedge clk);
      wr = 1'b1; be = 2'b11; addr = 32'h20; wdata = 32'h99999999; req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      reset_n = 1'b0;
      #1;
      check("abort_gnt", {32'h0, gnt}, 33'd0);
      check("abort_rvalid", {32'h0, rvalid}, 33'd0);
      check("abort_rd_err", {err, rd}, 33'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      issue(1'b0, 2'b11, 32'h20, 32'h0, 32'h11111111, 1'b0);

      // Reset during RESP kills the strobe at once; memory survives reset.
      #1 reset_n = 1'b0;
      #1 check("resp_reset_rvalid", {32'h0, rvalid}, 33'd0);
      @(negedge clk);
      reset_n = 1'b1;
      issue(1'b0, 2'b11, 32'h20, 32'h0, 32'h11111111, 1'b0);
      issue(1'b0, 2'b11, 32'h10, 32'h0, 32'hAA223344, 1'b0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 33'(sb.size()), 33'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/yarp_data_ram.md
YARP_DATA_RAM -- requirements
Module: yarp_data_ram

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning storage size in 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning wait states between grant and response (0..15).
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have data_mem_req_i  input  1  request valid, held by requester until granted.
REQ-005 SHALL have data_mem_addr_i  input  32  byte address.
REQ-006 SHALL have data_mem_byte_en_i  input  2  access size: 2'b00 byte, 2'b01 half-word, 2'b11 word, 2'b10 illegal.
REQ-007 SHALL have data_mem_wr_i  input  1  1 = store, 0 = load.
REQ-008 SHALL have data_mem_wr_data_i  input  32  store data, right-justified.
REQ-009 SHALL have data_mem_gnt_o  output  1  request accepted this cycle.
REQ-010 SHALL have data_mem_rvalid_o  output  1  one-cycle response strobe.
REQ-011 SHALL have data_mem_rd_data_o  output  32  load data, right-justified, upper bits zero.
REQ-012 SHALL have data_mem_err_o  output  1  error flag, valid with rvalid.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 In IDLE, gnt_o SHALL equal req_i combinationally; on req_i=1 SHALL capture addr, byte_en, wr, wr_data; next state is WAIT if WAIT_CYCLES>0, else RESP.
REQ-015 WAIT SHALL load a counter with WAIT_CYCLES at grant, decrement each cycle, and go to RESP on the cycle the counter reaches 1.
REQ-016 RESP SHALL assert rvalid_o for exactly one cycle, then return to IDLE; gnt_o SHALL be 0 in WAIT and RESP, and req_i there SHALL be ignored.
REQ-017 Latency: grant at cycle T gives rvalid_o at cycle T+1+WAIT_CYCLES; back-to-back throughput SHALL be one request per 2+WAIT_CYCLES cycles.
REQ-018 Stores SHALL commit, and loads SHALL sample, on the clock edge entering RESP.
REQ-019 Byte store SHALL write wr_data[7:0] to lane addr[1:0]; half store SHALL write wr_data[15:0] to lanes {addr[1],0} and {addr[1],1}; word store SHALL write all lanes. Other lanes SHALL be unchanged.
REQ-020 Loads SHALL return the selected byte or half shifted to bit 0 with zero fill; words SHALL be returned unchanged. Sign/zero extension is the requester's job.
REQ-021 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; any set bit above that range SHALL be out-of-range.
REQ-022 Error SHALL be flagged when byte_en=2'b10, half with addr[0]=1, word with addr[1:0]!=0, or out-of-range: no write, rd_data_o=0, err_o=1 with rvalid_o.
REQ-023 Store responses SHALL have rd_data_o=0; rd_data_o and err_o SHALL be 0 whenever rvalid_o=0.

Reset
REQ-024 On reset_n=0: state IDLE, counter 0, gnt_o=0, rvalid_o=0, rd_data_o=0, err_o=0, regardless of clk.
REQ-025 Reset in WAIT SHALL abort the transaction with no store committed and no response; reset in RESP SHALL suppress the remaining strobe.
REQ-026 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-027 WAIT_CYCLES=1: word store 0xDEADBEEF @0x10, then word load @0x10 -> gnt same cycle as req, rvalid 2 cycles later, rd_data=0xDEADBEEF, err=0.
REQ-028 Byte store 0xAA @0x13 over word 0x11223344 @0x10; byte load @0x13 -> 0x000000AA; word load @0x10 -> 0xAA223344.
REQ-029 Half load @0x12 of 0xAA223344 -> 0x0000AA22; half load @0x11 -> rvalid, err=1, rd_data=0, memory unchanged.
REQ-030 DEPTH_WORDS=1024: word store @0x1000 -> err=1, no alias write to @0x0 (load @0x0 unchanged).
REQ-031 req held high continuously with WAIT_CYCLES=0 -> gnt every 2nd cycle, rvalid every 2nd cycle offset by one.
REQ-032 Store @0x20 granted, reset_n pulsed low during WAIT -> outputs 0 immediately, no rvalid, later load @0x20 returns prior contents.
